// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO-side and serial-side signals of the UART transmitter.
interface fifo_uart_tx_if #(
    parameter int DATA_W = 8
);
    logic              enable;
    logic              stack_empty;
    logic [DATA_W-1:0] Data_out;
    logic              read_from_stack;
    logic              tx;
    logic              busy;
    logic              byte_done;

    modport master (
        input  enable, stack_empty, Data_out,
        output read_from_stack, tx, busy, byte_done
    );

    modport slave (
        output enable, stack_empty, Data_out,
        input  read_from_stack, tx, busy, byte_done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a FIFO and sends them as 8N1 frames, LSB first.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.master bus
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              rd_q, rd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bit_end;

    always_comb begin
        bit_end = cnt_q == LAST_CNT;
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE:    if (bus.enable && !bus.stack_empty) state_d = FETCH;
            FETCH:   state_d = LOAD;
            LOAD:    begin
                state_d = START;
                shreg_d = bus.Data_out;
            end
            START:   if (bit_end) begin
                state_d = DATA;
                idx_d   = '0;
            end
            DATA:    if (bit_end) begin
                idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                state_d = (idx_q == LAST_IDX) ? STOP : DATA;
            end
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // the baud counter only runs during serial bits and restarts at every bit boundary
        cnt_d  = (state_q inside {START, DATA, STOP} && !bit_end) ? cnt_q + 1'b1 : '0;
        // outputs are computed from the next state so that they are registered yet aligned with it
        tx_d   = (state_d == START) ? 1'b0 : (state_d == DATA) ? shreg_d[idx_d] : 1'b1;
        rd_d   = state_d == FETCH;
        busy_d = state_d != IDLE;
        done_d = (state_d == STOP) && (cnt_d == LAST_CNT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx              = tx_q;
    assign bus.read_from_stack = rd_q;
    assign bus.busy            = busy_q;
    assign bus.byte_done       = done_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: two transmitters (4 and 2 clocks per bit) against a frame-timing model.
module tb_fifo_uart_tx;
    localparam int W    = 8;
    localparam int CPB0 = 4;
    localparam int CPB1 = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b0;
    logic         se   [2];
    logic [W-1:0] dout [2];
    logic [3:0]   obs  [2];
    int           n_chk  = 0;
    int           n_fail = 0;

    bit           inf      [2];
    int           k        [2];
    logic [W-1:0] mb       [2];
    logic [W-1:0] fq       [2][$];
    logic [W-1:0] eq       [2][$];
    logic [W-1:0] popped   [2];
    bit           load_nxt [2];
    int           pops     [2];
    int           run      [2];

    fifo_uart_tx_if #(.DATA_W(W)) b0 ();
    fifo_uart_tx_if #(.DATA_W(W)) b1 ();

    assign b0.enable      = en;
    assign b0.stack_empty = se[0];
    assign b0.Data_out    = dout[0];
    assign b1.enable      = en;
    assign b1.stack_empty = se[1];
    assign b1.Data_out    = dout[1];
    assign obs[0] = {b0.tx, b0.busy, b0.read_from_stack, b0.byte_done};
    assign obs[1] = {b1.tx, b1.busy, b1.read_from_stack, b1.byte_done};

    fifo_uart_tx #(.CLKS_PER_BIT(CPB0), .DATA_W(W)) u0 (.clk(clk), .rst(rst), .bus(b0.master));
    fifo_uart_tx #(.CLKS_PER_BIT(CPB1), .DATA_W(W)) u1 (.clk(clk), .rst(rst), .bus(b1.master));

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int cpb(int d);
        return d == 0 ? CPB0 : CPB1;
    endfunction

    // frame cycle k: 0 pop, 1 load, then 10 bit slots of cpb cycles each (start, data LSB first, stop)
    function automatic logic [3:0] expect_out(int d);
        int   t;
        int   slot;
        logic txe;
        t    = 2 + (W + 2) * cpb(d);
        slot = (k[d] - 2) / cpb(d);
        if (!inf[d]) return 4'b1000;
        txe = k[d] < 2 ? 1'b1 : slot == 0 ? 1'b0 : slot <= W ? mb[d][slot - 1] : 1'b1;
        return {txe, 1'b1, k[d] == 0, k[d] == t - 1};
    endfunction

    task automatic advance();
        for (int d = 0; d < 2; d++) begin
            if (!rst) inf[d] = 1'b0;
            else if (inf[d]) begin
                k[d]++;
                if (k[d] == 2 + (W + 2) * cpb(d)) inf[d] = 1'b0;
            end else if (en && !se[d] && eq[d].size() > 0) begin
                inf[d] = 1'b1;
                k[d]   = 0;
                mb[d]  = eq[d].pop_front();
            end
        end
    endtask

    task automatic tick();
        advance();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            logic [3:0] e;
            e = expect_out(d);
            chk($sformatf("dut%0d out{tx,busy,rd,done} k=%0d", d, k[d]), 32'(obs[d]), 32'(e));
            run[d] = obs[d][2] ? run[d] + 1 : 0;
            if (obs[d][0]) chk($sformatf("dut%0d busy_len", d), run[d], 2 + (W + 2) * cpb(d));
            dout[d]     = load_nxt[d] ? popped[d] : W'($urandom);
            load_nxt[d] = 1'b0;
            if (obs[d][1]) begin
                pops[d]++;
                chk($sformatf("dut%0d pop_nonempty", d), 32'(fq[d].size() > 0), 1);
                if (fq[d].size() > 0) begin
                    popped[d]   = fq[d].pop_front();
                    load_nxt[d] = 1'b1;
                end
            end
            se[d] = fq[d].size() == 0;
        end
    endtask

    task automatic push(int d, logic [W-1:0] b);
        fq[d].push_back(b);
        eq[d].push_back(b);
        se[d] = 1'b0;
    endtask

    task automatic drain(int lim);
        int i;
        for (i = 0; i < lim; i++) begin
            if (!inf[0] && !inf[1] && fq[0].size() == 0 && fq[1].size() == 0) break;
            tick();
        end
        chk("drain_in_time", 32'(i < lim), 1);
        chk("drain_busy", {b1.busy, b0.busy}, 0);
    endtask

    initial begin
        se[0]   = 1'b1;
        se[1]   = 1'b1;
        dout[0] = '0;
        dout[1] = '0;
        repeat (3) tick();
        rst = 1'b1;
        en  = 1'b1;
        repeat (100) tick();
        push(0, 8'hA5);
        push(1, 8'h81);
        drain(200);
        chk("pops_first0", pops[0], 1);
        chk("pops_first1", pops[1], 1);
        for (int d = 0; d < 2; d++) begin
            push(d, 8'h00);
            push(d, 8'hFF);
        end
        drain(300);
        chk("pops_b2b0", pops[0], 3);
        chk("pops_b2b1", pops[1], 3);
        for (int d = 0; d < 2; d++) begin
            push(d, 8'h3C);
            push(d, 8'h5A);
        end
        for (int i = 0; i < 100 && !(inf[0] && k[0] >= 2 + 2 * CPB0); i++) tick();
        en = 1'b0;
        repeat (150) tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d hold_pops", d), pops[d], 4);
            chk($sformatf("dut%0d hold_left", d), fq[d].size(), 1);
        end
        chk("hold_busy", {b1.busy, b0.busy}, 0);
        en = 1'b1;
        drain(300);
        for (int d = 0; d < 2; d++) begin
            push(d, 8'hC3);
            push(d, 8'h96);
        end
        for (int i = 0; i < 100 && !(inf[0] && k[0] == 2 + 3 * CPB0 + 1); i++) tick();
        chk("rst_point_busy", b0.busy, 1);
        rst = 1'b0;
        #1;
        chk("rst_async0", 32'(obs[0]), 32'(4'b1000));
        chk("rst_async1", 32'(obs[1]), 32'(4'b1000));
        repeat (3) tick();
        rst = 1'b1;
        drain(300);
        chk("pops_after_rst0", pops[0], 7);
        chk("pops_after_rst1", pops[1], 7);
        repeat (1500) begin
            if ($urandom_range(0, 9) == 0) push(int'($urandom_range(0, 1)), W'($urandom));
            if ($urandom_range(0, 39) == 0) en = ~en;
            tick();
        end
        en = 1'b1;
        drain(5000);
        chk("model_fifo0_empty", eq[0].size(), 0);
        chk("model_fifo1_empty", eq[1].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
